rr_arbiter_16: RTL and testbench

//   Round-robin arbiter that shares one resource among N requesters.

---
 rtl/rr_arbiter_16.sv | 123 ++++++++++++
 tb/tb_rr_arbiter_16.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_16.sv
// Round-robin arbiter for N requesters with registered one-hot grant,
// binary grant index, and an optional per-owner hold limit.
module rr_arbiter_16 #(
    parameter int N        = 16,
    parameter int IW       = $clog2(N),
    parameter int MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic          done,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid
);

    // Hold counter only needs to reach MAX_HOLD; unlimited mode saturates at all-ones.
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 8;
    localparam logic [HW-1:0] HOLD_SAT = (MAX_HOLD != 0) ? HW'(MAX_HOLD) : {HW{1'b1}};

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]    state_q,    state_d;
    logic [N-1:0]  gnt_q,      gnt_d;
    logic [IW-1:0] gnt_idx_q,  gnt_idx_d;
    logic          gnt_vld_q,  gnt_vld_d;
    logic [IW-1:0] ptr_q,      ptr_d;
    logic [HW-1:0] hold_q,     hold_d;

    logic [IW-1:0] own_nxt;
    logic [IW-1:0] start;
    logic [IW-1:0] win;
    logic          found;
    logic          rel;

    // Start point after the current owner, wrapping modulo N.
    always_comb begin
        own_nxt = (gnt_idx_q == IW'(N - 1)) ? '0 : gnt_idx_q + 1'b1;
        start   = (state_q == GRANT) ? own_nxt : ptr_q;
        rel     = done || !req[gnt_idx_q] || ((MAX_HOLD != 0) && (hold_q == HOLD_SAT));
    end

    // Circular priority search: first requester at or after start.
    always_comb begin
        int j;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(start) + k;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                found = 1'b1;
                win   = IW'(j);
            end
        end
    end

    // Next-state: grant from idle, hold, or release with back-to-back handoff.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        gnt_vld_d = gnt_vld_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d      = GRANT;
                    gnt_d        = '0;
                    gnt_d[win]   = 1'b1;
                    gnt_idx_d    = win;
                    gnt_vld_d    = 1'b1;
                    hold_d       = HW'(1);
                end
            end
            default: begin
                if (rel) begin
                    ptr_d = own_nxt;
                    if (found) begin
                        gnt_d      = '0;
                        gnt_d[win] = 1'b1;
                        gnt_idx_d  = win;
                        hold_d     = HW'(1);
                    end else begin
                        state_d   = IDLE;
                        gnt_d     = '0;
                        gnt_idx_d = '0;
                        gnt_vld_d = 1'b0;
                        hold_d    = '0;
                    end
                end else if (hold_q != HOLD_SAT) begin
                    hold_d = hold_q + 1'b1;
                end
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            gnt_vld_q <= 1'b0;
            ptr_q     <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            gnt_vld_q <= gnt_vld_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_vld_q;

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Directed testbench for rr_arbiter_16 (N=16, MAX_HOLD=8).
module tb_rr_arbiter_16;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] req;
    logic        done;
    logic [15:0] gnt;
    logic [3:0]  gnt_idx;
    logic        gnt_valid;

    int errors = 0;
    int checks = 0;

    rr_arbiter_16 #(.N(16), .IW(4), .MAX_HOLD(8)) dut (
        .clk(clk), .reset(reset), .req(req), .done(done),
        .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; done = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 16'hFFFF; done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if ({gnt_valid, gnt_idx, gnt} !== {1'b0, 4'd0, 16'h0000}) begin
                $display("FAIL reset_hold cyc%0d: got v=%0b idx=%0d gnt=%h, want v=0 idx=0 gnt=0000",
                         c, gnt_valid, gnt_idx, gnt);
                errors++;
            end
        end
        reset = 1'b0;
        step();
        checks++;
        if ({gnt_valid, gnt_idx, gnt} !== {1'b1, 4'd0, 16'h0001}) begin
            $display("FAIL reset_first_grant: got v=%0b idx=%0d gnt=%h, want v=1 idx=0 gnt=0001",
                     gnt_valid, gnt_idx, gnt);
            errors++;
        end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_seq [5] = '{4'd0, 4'd8, 4'd15, 4'd0, 4'd8};
        do_reset();
        req = 16'h8101; done = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if ({gnt_valid, gnt_idx, gnt} !== {1'b1, exp_seq[c], 16'(1) << exp_seq[c]}) begin
                $display("FAIL rotation step%0d: got v=%0b idx=%0d gnt=%h, want v=1 idx=%0d",
                         c, gnt_valid, gnt_idx, gnt, exp_seq[c]);
                errors++;
            end
        end
        done = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        req = 16'h8000;
        step();
        checks++;
        if (gnt_idx !== 4'd15 || gnt_valid !== 1'b1) begin
            $display("FAIL wrap_setup: got v=%0b idx=%0d, want v=1 idx=15", gnt_valid, gnt_idx);
            errors++;
        end
        req = 16'h0003;
        step();
        checks++;
        if ({gnt_valid, gnt_idx, gnt} !== {1'b1, 4'd0, 16'h0001}) begin
            $display("FAIL wrap: got v=%0b idx=%0d gnt=%h, want v=1 idx=0 gnt=0001",
                     gnt_valid, gnt_idx, gnt);
            errors++;
        end
    endtask

    task automatic test_req_drop();
        do_reset();
        req = 16'h0008;
        step();
        req = 16'h0018;
        step();
        checks++;
        if ({gnt_valid, gnt_idx, gnt} !== {1'b1, 4'd3, 16'h0008}) begin
            $display("FAIL no_preempt: got v=%0b idx=%0d gnt=%h, want v=1 idx=3 gnt=0008",
                     gnt_valid, gnt_idx, gnt);
            errors++;
        end
        req = 16'h0010;
        step();
        checks++;
        if ({gnt_valid, gnt_idx, gnt} !== {1'b1, 4'd4, 16'h0010}) begin
            $display("FAIL req_drop: got v=%0b idx=%0d gnt=%h, want v=1 idx=4 gnt=0010",
                     gnt_valid, gnt_idx, gnt);
            errors++;
        end
        req = 16'h0000;
        step();
        checks++;
        if ({gnt_valid, gnt_idx, gnt} !== {1'b0, 4'd0, 16'h0000}) begin
            $display("FAIL go_idle: got v=%0b idx=%0d gnt=%h, want v=0 idx=0 gnt=0000",
                     gnt_valid, gnt_idx, gnt);
            errors++;
        end
    endtask

    task automatic test_max_hold();
        logic [3:0] exp;
        do_reset();
        req = 16'h0024; done = 1'b0;
        for (int c = 0; c < 17; c++) begin
            exp = (c >= 8 && c < 16) ? 4'd5 : 4'd2;
            step();
            checks++;
            if ({gnt_valid, gnt_idx, gnt} !== {1'b1, exp, 16'(1) << exp}) begin
                $display("FAIL max_hold cyc%0d: got v=%0b idx=%0d gnt=%h, want v=1 idx=%0d",
                         c, gnt_valid, gnt_idx, gnt, exp);
                errors++;
            end
        end
    endtask

    task automatic test_sole_requester();
        do_reset();
        req = 16'h0004; done = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if ({gnt_valid, gnt_idx, gnt} !== {1'b1, 4'd2, 16'h0004}) begin
                $display("FAIL sole_regrant cyc%0d: got v=%0b idx=%0d gnt=%h, want v=1 idx=2 gnt=0004",
                         c, gnt_valid, gnt_idx, gnt);
                errors++;
            end
        end
        done = 1'b0;
    endtask

    task automatic test_mid_reset();
        do_reset();
        req = 16'h0080;
        step();
        checks++;
        if (gnt_idx !== 4'd7 || gnt_valid !== 1'b1) begin
            $display("FAIL mid_reset_setup: got v=%0b idx=%0d, want v=1 idx=7", gnt_valid, gnt_idx);
            errors++;
        end
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if ({gnt_valid, gnt_idx, gnt} !== {1'b0, 4'd0, 16'h0000}) begin
                $display("FAIL mid_reset cyc%0d: got v=%0b idx=%0d gnt=%h, want all zero",
                         c, gnt_valid, gnt_idx, gnt);
                errors++;
            end
        end
        reset = 1'b0;
        step();
        checks++;
        if ({gnt_valid, gnt_idx, gnt} !== {1'b1, 4'd7, 16'h0080}) begin
            $display("FAIL mid_reset_regrant: got v=%0b idx=%0d gnt=%h, want v=1 idx=7 gnt=0080",
                     gnt_valid, gnt_idx, gnt);
            errors++;
        end
    endtask

    initial begin
        reset = 1'b1; req = '0; done = 1'b0;
        test_reset();
        test_rotation();
        test_wrap();
        test_req_drop();
        test_max_hold();
        test_sole_requester();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
